// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The slave modport is the cache's view; master is the environment (fetcher + arbiter).
interface icache_if;
    logic [31:0] addr;
    logic        rn;
    logic [31:0] Inst;
    logic        Read_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_data;
    logic        mem_valid;

    modport slave (
        input  addr, rn, mem_gnt, mem_data, mem_valid,
        output Inst, Read_ready, mem_req, mem_addr
    );

    modport master (
        output addr, rn, mem_gnt, mem_data, mem_valid,
        input  Inst, Read_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache; 16-byte lines are refilled one byte per beat.
// Defining ICACHE_PERF_EN adds hit_cnt/miss_cnt performance counters.
module icache #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
`ifdef ICACHE_PERF_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    icache_if.slave     bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2, RESP = 2'd3} state_t;
    state_t state_r, state_nx_s;

    logic [LINES-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [127:0]       data_mem [LINES];

    logic [ADDR_W-1:2]  addr_r;
    logic [3:0]         cnt_r;
    logic [119:0]       buf_r;
    logic [31:0]        inst_r;
    logic [31:0]        mem_addr_r;
    logic               rr_r;
    logic               mem_req_r;

    logic [1:0]         in_off_s;
    logic [INDEX_W-1:0] in_idx_s;
    logic [TAG_W-1:0]   in_tag_s;
    logic               hit_s;
    logic               fill_done_s;
    logic [127:0]       full_line_s;
    logic               unused_s;

    assign in_off_s    = bus.addr[3:2];
    assign in_idx_s    = bus.addr[4+INDEX_W-1:4];
    assign in_tag_s    = bus.addr[ADDR_W-1:4+INDEX_W];
    assign hit_s       = valid_r[in_idx_s] && (tag_mem[in_idx_s] == in_tag_s);
    assign fill_done_s = (state_r == FILL) && bus.mem_valid && (cnt_r == 4'd15);
    // The last byte is forwarded straight from the bus rather than waiting for the buffer.
    assign full_line_s = {bus.mem_data, buf_r};
    assign unused_s    = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};

    assign bus.Inst       = inst_r;
    assign bus.Read_ready = rr_r;
    assign bus.mem_req    = mem_req_r;
    assign bus.mem_addr   = mem_addr_r;

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.rn) begin
                    state_nx_s = hit_s ? RESP : REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = REQ;
                end
            end
            FILL: begin
                if (fill_done_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = FILL;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (rdy) begin
            state_r <= state_nx_s;
        end
    end

    // Request capture, refill sequencing and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r     <= '0;
            cnt_r      <= 4'd0;
            buf_r      <= 120'd0;
            inst_r     <= 32'd0;
            mem_addr_r <= 32'd0;
            rr_r       <= 1'b0;
            mem_req_r  <= 1'b0;
        end else if (rdy) begin
            rr_r <= (state_nx_s == RESP);
            case (state_r)
                IDLE: begin
                    if (bus.rn) begin
                        addr_r <= bus.addr[ADDR_W-1:2];
                        if (hit_s) begin
                            inst_r <= data_mem[in_idx_s][{in_off_s, 5'b00000} +: 32];
                        end else begin
                            mem_addr_r <= {{(32-ADDR_W){1'b0}}, bus.addr[ADDR_W-1:4], 4'b0000};
                            mem_req_r  <= 1'b1;
                            cnt_r      <= 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_r <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.mem_valid) begin
                        cnt_r <= cnt_r + 4'd1;
                        if (cnt_r == 4'd15) begin
                            inst_r <= full_line_s[{addr_r[3:2], 5'b00000} +: 32];
                        end else begin
                            buf_r[{cnt_r, 3'b000} +: 8] <= bus.mem_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Valid bits: cleared by reset, set only when a line is completely filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= '0;
        end else if (rdy && fill_done_s) begin
            valid_r[addr_r[4+INDEX_W-1:4]] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy && fill_done_s) begin
            tag_mem[addr_r[4+INDEX_W-1:4]]  <= addr_r[ADDR_W-1:4+INDEX_W];
            data_mem[addr_r[4+INDEX_W-1:4]] <= full_line_s;
        end
    end

`ifdef ICACHE_PERF_EN
    // Hit/miss counters, one increment per accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else if (rdy && (state_r == IDLE) && bus.rn) begin
            if (hit_s) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache directly upstream of the fetch stage.
- Serves the fetcher's `addr`/`rn` requests, returning `Inst` with a one-cycle `Read_ready` pulse.
- On a miss, refills a 16-byte line from the byte-wide memory arbiter port.
- Read-only: no write path, no coherence.

Parameters:
- INDEX_W, 6, log2 of the number of lines (default 64 lines x 16 B = 1 KiB).
- ADDR_W, 18, significant address bits; `addr[31:ADDR_W]` is ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global ready; when low, all state and outputs freeze
- addr  in  32  fetch address from the fetcher; word-aligned; only `[ADDR_W-1:0]` used
- rn  in  1  read request from the fetcher; level, may stay high across requests
- Inst  out  32  fetched instruction word; valid while `Read_ready`=1
- Read_ready  out  1  one-cycle pulse: `Inst` valid for the accepted request
- mem_req  out  1  line-refill request to the memory arbiter
- mem_addr  out  32  line base address `{14'b0, addr[17:4], 4'b0}`
- mem_gnt  in  1  arbiter accepts the request (one-cycle pulse)
- mem_data  in  8  refill byte
- mem_valid  in  1  `mem_data` valid; bytes arrive in ascending address order, gaps allowed

Behaviour:
- Address split:
  - offset = `addr[3:2]` (word in line).
  - index = `addr[4+INDEX_W-1:4]`.
  - tag = `addr[ADDR_W-1:4+INDEX_W]`.
- Storage: per line, a valid bit, a tag and 4 words.
- FSM states: IDLE, REQ, FILL, RESP.
- IDLE:
  - Request accepted only when `rn`=1; `addr` is captured.
  - Hit (valid & tag equal): `Inst` <= line word[offset]; go to RESP.
  - Miss: `mem_addr` <= line base; `mem_req` <= 1; byte counter <= 0; go to REQ.
- REQ:
  - Hold `mem_req`=1 and `mem_addr` stable until `mem_gnt`=1.
  - On `mem_gnt`: `mem_req` <= 0; go to FILL.
- FILL:
  - Each `mem_valid` stores `mem_data` at byte[counter] of the line buffer; counter += 1 (4 bits).
  - On the 16th byte (counter==15 with `mem_valid`): write the line, tag and valid=1 into the array.
  - At the same time, `Inst` <= assembled word[offset], little-endian `{b3,b2,b1,b0}`, with the 16th byte forwarded.
  - Go to RESP.
  - `mem_valid` outside FILL is ignored.
- RESP:
  - `Read_ready`=1 for exactly this cycle; `rn`/`addr` ignored (stale); go to IDLE.
  - `Inst` holds its value until the next RESP.
- Latency (rdy=1 throughout):
  - Hit: `Read_ready` in the cycle after acceptance; at most one instruction per 2 cycles.
  - Miss: acceptance + 1 cycle REQ minimum + 16 `mem_valid` beats + RESP.
- Replacement: direct-mapped overwrite; a miss to a valid line evicts it.
- Valid bit is set only at fill completion; a partially filled line is never reported as a hit.
- `rdy`=0: no state, counter, array or output changes.
  - The memory arbiter is gated by the same `rdy`, so no `mem_valid` arrives while `rdy`=0.
  - If `Read_ready` is high when `rdy` drops, it stays high until the first `rdy`=1 edge completes RESP.
- Reset (async, any state, including mid-REQ/FILL):
  - All valid bits cleared; state IDLE; counter 0.
  - `Read_ready`=0, `mem_req`=0, `Inst`=0, `mem_addr`=0.
  - A partially filled line is discarded.
  - Bytes from an abandoned refill that arrive after reset release are ignored, since state is IDLE.

Optional Feature:
- Macro: `ICACHE_PERF_EN`.
- Defined: adds outputs `hit_cnt` (32) and `miss_cnt` (32).
  - Reset to 0 by `rst`.
  - Incremented once per accepted IDLE request, hit or miss respectively.
  - Wrap modulo 2^32; frozen while `rdy`=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss at `addr` 0x0, memory bytes 0x13,0x05,0x00,0x00,... → `mem_req`=1 with `mem_addr`=0x0; after `mem_gnt` and 16 `mem_valid` beats → `Read_ready` pulse with `Inst`=0x00000513.
- After the fill, request `addr` 0x4 → no `mem_req`; `Read_ready` one cycle after acceptance; `Inst` = bytes 4..7 of the line.
- Conflict: 0x0 filled, then request 0x400 (same index 0, different tag) → miss; refill from 0x400; then re-request 0x0 → miss again.
- Assert `rst`=0 after the 7th `mem_valid` of a fill at 0x20 → outputs zero immediately; after release, request 0x20 → new `mem_req`, no hit.
- Hold `rdy`=0 for 5 cycles during REQ and during RESP → `mem_req`, `mem_addr`, `Read_ready` held; pulse completes exactly one `rdy`=1 cycle later.
- With `ICACHE_PERF_EN`: miss 0x0, hits 0x4, 0x8, 0xC → `miss_cnt`=1, `hit_cnt`=3.
